// File: rtl/instr_loader.sv
// instr_loader: streams W-bit machine-code words from a valid/ready source into
// consecutive instruction-memory addresses starting at 0, holding the core in
// stall for the duration of the load.
// Optional feature macro: LOADER_CHECKSUM_EN -- adds a trailing checksum word
// (running XOR of the data words) that is compared to set Err.
module instr_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [D:0]   Len,
    input  logic         InValid,
    input  logic [W-1:0] InData,
    output logic         InReady,
    output logic         WrEn,
    output logic [D-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic         Stall,
    output logic         Done,
    output logic         Err
);

    // Full memory depth; Len is clipped to this so the address never wraps.
    localparam logic [D:0] DEPTH = {1'b1, {D{1'b0}}};
    localparam logic [D:0] ONE   = {{D{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
`ifdef LOADER_CHECKSUM_EN
        , S_CHK = 2'd3
`endif
    } state_t;

    state_t     state;
    logic [D:0] count;
    logic [D:0] len_q;
    logic [D:0] len_clip;
    logic       last_word;

    assign len_clip  = (Len > DEPTH) ? DEPTH : Len;
    assign last_word = (count == len_q - ONE);

`ifdef LOADER_CHECKSUM_EN
    logic [W-1:0] cks;

    // Ready depends on state only so the source never sees a combinational loop.
    assign InReady = (state == S_LOAD) || (state == S_CHK);
`else
    assign InReady = (state == S_LOAD);
    assign Err     = 1'b0;
`endif

    // Loader FSM with all outputs registered; WrEn is a one-cycle pulse per accept.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= S_IDLE;
            WrEn   <= 1'b0;
            WrAddr <= '0;
            WrData <= '0;
            Stall  <= 1'b0;
            Done   <= 1'b0;
            count  <= '0;
            len_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            Err    <= 1'b0;
            cks    <= '0;
`endif
        end else begin
            WrEn <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        count <= '0;
                        len_q <= len_clip;
                        Done  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        Err   <= 1'b0;
                        cks   <= '0;
`endif
                        if (Len == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            // Empty image still carries its checksum word.
                            state <= S_CHK;
                            Stall <= 1'b1;
`else
                            state <= S_DONE;
                            Done  <= 1'b1;
                            Stall <= 1'b0;
`endif
                        end else begin
                            state <= S_LOAD;
                            Stall <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (InValid) begin
                        WrEn   <= 1'b1;
                        WrAddr <= count[D-1:0];
                        WrData <= InData;
                        count  <= count + ONE;
`ifdef LOADER_CHECKSUM_EN
                        cks    <= cks ^ InData;
`endif
                        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            // Done rises alongside the final write pulse.
                            state <= S_DONE;
                            Done  <= 1'b1;
                            Stall <= 1'b0;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    // Checksum word is consumed but never written to memory.
                    if (InValid) begin
                        state <= S_DONE;
                        Done  <= 1'b1;
                        Stall <= 1'b0;
                        Err   <= (InData != cks);
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed scenarios plus randomized loads, checked
// against a queue-based model of the words that should land in memory.
module tb_instr_loader;

    localparam int D     = 12;
    localparam int W     = 9;
    localparam int DEPTH = 1 << D;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [D:0]   Len;
    logic         InValid;
    logic [W-1:0] InData;
    logic         InReady;
    logic         WrEn;
    logic [D-1:0] WrAddr;
    logic [W-1:0] WrData;
    logic         Stall;
    logic         Done;
    logic         Err;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] wq[$];
    logic [D-1:0] log_addr[$];
    logic [W-1:0] log_data[$];

    instr_loader #(.D(D), .W(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Len(Len),
        .InValid(InValid), .InData(InData), .InReady(InReady),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .Stall(Stall), .Done(Done), .Err(Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Record every memory write for the end-of-load scoreboard.
    always @(negedge Clk) begin
        if (WrEn === 1'b1) begin
            log_addr.push_back(WrAddr);
            log_data.push_back(WrData);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete load from IDLE/DONE. prob<0 alternates InValid 1,0,1,0.
    task automatic run_load(input int len, input int prob, input bit mid_start,
                            input logic [W-1:0] ck_flip, input string tag);
        int n, sent, budget, c;
        bit acc, done_exp;
        logic [W-1:0] x;
        n = (len > DEPTH) ? DEPTH : len;
        while (wq.size() < n) wq.push_back(W'($urandom));
        x = '0;
        for (int i = 0; i < n; i++) x ^= wq[i];
        log_addr.delete();
        log_data.delete();

        Start = 1'b1; Len = (D+1)'(len); InValid = 1'b0;
        tick();
        Start = 1'b0;
        chk({tag, ".start_wren"}, 32'(WrEn), 0);
        chk({tag, ".start_err"}, 32'(Err), 0);
        if (n == 0 && !CKS) begin
            chk({tag, ".empty_done"}, 32'(Done), 1);
            chk({tag, ".empty_stall"}, 32'(Stall), 0);
            chk({tag, ".empty_ready"}, 32'(InReady), 0);
        end else begin
            chk({tag, ".start_stall"}, 32'(Stall), 1);
            chk({tag, ".start_done"}, 32'(Done), 0);
        end

        sent = 0; c = 0; budget = 20 * n + 50;
        while (sent < n && budget > 0) begin
            InValid = (prob < 0) ? (c % 2 == 0) : (int'($urandom_range(0, 99)) < prob);
            InData  = InValid ? wq[sent] : W'($urandom);
            if (mid_start) begin
                Start = ($urandom_range(0, 3) == 0);
                Len   = (D+1)'($urandom_range(0, 20));
            end
            chk({tag, ".ready"}, 32'(InReady), 1);
            acc = InValid;
            tick();
            Start = 1'b0;
            budget--; c++;
            chk({tag, ".wren"}, 32'(WrEn), 32'(acc));
            if (acc) begin
                chk({tag, ".wraddr"}, 32'(WrAddr), sent);
                chk({tag, ".wrdata"}, 32'(WrData), 32'(wq[sent]));
                sent++;
            end
            done_exp = (sent == n) && !CKS;
            chk({tag, ".load_done"}, 32'(Done), 32'(done_exp));
            chk({tag, ".load_stall"}, 32'(Stall), 32'(!done_exp));
        end
        checks++;
        assert (sent == n) else begin
            failures++;
            $error("FAIL %s.timeout observed=%0d expected=%0d", tag, sent, n);
        end

`ifdef LOADER_CHECKSUM_EN
        begin
            bit got;
            got = 1'b0; budget = 60;
            while (!got && budget > 0) begin
                InValid = ($urandom_range(0, 1) == 1);
                InData  = InValid ? (x ^ ck_flip) : W'($urandom);
                chk({tag, ".chk_ready"}, 32'(InReady), 1);
                chk({tag, ".chk_stall"}, 32'(Stall), 1);
                chk({tag, ".chk_done"}, 32'(Done), 0);
                acc = InValid;
                tick();
                budget--;
                chk({tag, ".chk_wren"}, 32'(WrEn), 0);
                got = acc;
            end
            checks++;
            assert (got) else begin
                failures++;
                $error("FAIL %s.chk_timeout observed=%0d expected=%0d", tag, got, 1);
            end
        end
`endif

        chk({tag, ".end_done"}, 32'(Done), 1);
        chk({tag, ".end_stall"}, 32'(Stall), 0);
        chk({tag, ".end_err"}, 32'(Err), 32'(CKS && (ck_flip != '0)));

        // Stream words offered in DONE must be refused.
        InValid = 1'b1; InData = W'($urandom);
        repeat (2) begin
            chk({tag, ".done_ready"}, 32'(InReady), 0);
            tick();
            chk({tag, ".done_wren"}, 32'(WrEn), 0);
            chk({tag, ".done_hold"}, 32'(Done), 1);
        end
        InValid = 1'b0;

        chk({tag, ".nwrites"}, 32'(log_addr.size()), n);
        for (int i = 0; i < n && i < log_addr.size(); i++) begin
            if (log_addr[i] !== D'(i) || log_data[i] !== wq[i]) begin
                chk({tag, ".log_addr"}, 32'(log_addr[i]), i);
                chk({tag, ".log_data"}, 32'(log_data[i]), 32'(wq[i]));
            end
        end
        if (n > 0 && log_addr.size() > 0)
            chk({tag, ".last_addr"}, 32'(log_addr[log_addr.size()-1]), n - 1);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Len = '0; InValid = 1'b0; InData = '0;

        // Reset held two cycles with noise on the stream.
        repeat (2) begin
            InValid = 1'b1; InData = W'($urandom);
            tick();
        end
        chk("rst.wren", 32'(WrEn), 0);
        chk("rst.wraddr", 32'(WrAddr), 0);
        chk("rst.wrdata", 32'(WrData), 0);
        chk("rst.stall", 32'(Stall), 0);
        chk("rst.done", 32'(Done), 0);
        chk("rst.err", 32'(Err), 0);
        chk("rst.ready", 32'(InReady), 0);
        Reset = 1'b0;

        // IDLE ignores the stream.
        repeat (3) begin
            InValid = 1'b1; InData = W'($urandom);
            tick();
            chk("idle.ready", 32'(InReady), 0);
            chk("idle.wren", 32'(WrEn), 0);
            chk("idle.stall", 32'(Stall), 0);
        end
        InValid = 1'b0;

        wq = '{9'h07E, 9'h066, 9'h07A};
        run_load(3, 100, 1'b0, 9'h000, "t2");

        wq.delete();
        run_load(4, -1, 1'b1, 9'h000, "t3");

        wq.delete();
        run_load(0, 100, 1'b0, 9'h000, "t4_len0");
        wq.delete();
        run_load(DEPTH + 5, 100, 1'b0, 9'h000, "t4_over");

        // Reset after two of five words.
        wq.delete();
        for (int i = 0; i < 5; i++) wq.push_back(W'($urandom));
        log_addr.delete(); log_data.delete();
        Start = 1'b1; Len = (D+1)'(5);
        tick();
        Start = 1'b0;
        InValid = 1'b1; InData = wq[0];
        tick();
        InData = wq[1];
        tick();
        chk("t5.wraddr", 32'(WrAddr), 1);
        Reset = 1'b1; InData = wq[2];
        tick();
        Reset = 1'b0; InValid = 1'b0;
        chk("t5.wren", 32'(WrEn), 0);
        chk("t5.stall", 32'(Stall), 0);
        chk("t5.done", 32'(Done), 0);
        chk("t5.ready", 32'(InReady), 0);
        tick();
        chk("t5.partial", 32'(log_addr.size()), 2);
        run_load(5, 70, 1'b0, 9'h000, "t5_reload");

        wq = '{9'h07E, 9'h066};
        run_load(2, 100, 1'b0, 9'h000, "t6_good");
        wq = '{9'h07E, 9'h066};
        run_load(2, 100, 1'b0, 9'h001, "t6_bad");

        // Randomized loads restarting from DONE.
        repeat (10) begin
            logic [W-1:0] flip;
            flip = ($urandom_range(0, 1) == 1) ? W'($urandom_range(1, 511)) : '0;
            wq.delete();
            run_load($urandom_range(1, 40), $urandom_range(20, 100),
                     1'($urandom_range(0, 1)), flip, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
